mem_arbiter: RTL and testbench

Arbitrates the single-port unified instruction/data RAM between the instruction-fetch port and the load/store port of the RV32I core. It issues at most one memory access per cycle, with data priority and a starvation bound for fetch. It converts byte/half/word loads and stores into word-addressed accesses with byte-lane strobes, and returns aligned, extended load data one cycle after grant. It sits between the core datapath and the RAM macro, replacing direct array indexing in the core.

---
 rtl/mem_arbiter_if.sv | 41 ++++
 rtl/mem_arbiter.sv | 173 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch port, load/store port and RAM-side signals of the shared-memory arbiter.
// Latency: none; this is only a signal bundle.
// Backpressure: requesters hold req/addr until the matching gnt is seen.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [31:0]       i_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [1:0]        d_size;
  logic              d_signed;
  logic [31:0]       d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [31:0]       d_rdata;
  logic              d_err;

  logic              mem_en;
  logic [3:0]        mem_we;
  logic [ADDR_W-3:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_size, d_signed, d_wdata, mem_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, d_err,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_size, d_signed, d_wdata, mem_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, d_err,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port RAM arbiter, data priority with fetch starvation bound; ARB_RANGE_CHECK_EN adds fault checks.
// Latency: grant and RAM strobes combinational; rvalid/rdata one cycle after the accepting edge.
// Backpressure: requests are held until gnt; fetch is forced to win after MAX_WAIT consecutive denials.
module mem_arbiter #(
  parameter int unsigned       ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] DMEM_START = 32'h0020_0000,
  parameter logic [ADDR_W-1:0] DMEM_END   = 32'h0025_0000,
  parameter int unsigned       MAX_WAIT   = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_arbiter_if.slave bus
);

`ifdef ARB_RANGE_CHECK_EN
  localparam bit range_chk_en = 1'b1;
`else
  localparam bit range_chk_en = 1'b0;
`endif

  localparam int unsigned      CNT_W   = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  typedef enum logic [2:0] {
    RSP_NONE,
    RSP_I_RD,
    RSP_D_RD,
    RSP_D_WR,
    RSP_D_ERR
  } rsp_e;

  rsp_e             rsp_q, rsp_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic [1:0]       off_q, off_d;
  logic [1:0]       size_q, size_d;
  logic             sgn_q, sgn_d;

  logic        i_win, d_win;
  logic        d_misaligned, d_in_range, d_fault;
  logic [1:0]  d_off;
  logic [3:0]  d_strb;
  logic [31:0] d_wlane;
  logic [15:0] rd_half;
  logic [7:0]  rd_byte;
  logic [31:0] ld_val;

  // Fetch addresses are word-aligned; the low bits carry no information.
  logic unused_i_lsb;
  assign unused_i_lsb = ^bus.i_addr[1:0];

  // Lane steering and alignment for the current data request.
  always_comb begin
    d_off        = 2'b00;
    d_strb       = 4'b1111;
    d_wlane      = bus.d_wdata;
    d_misaligned = 1'b0;
    case (bus.d_size)
      2'd0: begin
        d_off   = bus.d_addr[1:0];
        d_strb  = 4'b0001 << bus.d_addr[1:0];
        d_wlane = {4{bus.d_wdata[7:0]}};
      end
      2'd1: begin
        d_off        = {bus.d_addr[1], 1'b0};
        d_strb       = 4'b0011 << {bus.d_addr[1], 1'b0};
        d_wlane      = {2{bus.d_wdata[15:0]}};
        d_misaligned = bus.d_addr[0];
      end
      default: begin
        d_misaligned = |bus.d_addr[1:0];
      end
    endcase
    d_in_range = (bus.d_addr >= DMEM_START) && (bus.d_addr < DMEM_END);
    d_fault    = range_chk_en && (d_misaligned || !d_in_range);
  end

  always_comb begin
    i_win = 1'b0;
    d_win = 1'b0;
    if (rst_n) begin
      if (bus.i_req && (starve_cnt_q == CNT_MAX)) begin
        i_win = 1'b1;
      end else if (bus.d_req) begin
        d_win = 1'b1;
      end else if (bus.i_req) begin
        i_win = 1'b1;
      end
    end
  end

  // A faulting data access still wins the slot but never reaches the RAM.
  always_comb begin
    bus.i_gnt     = i_win;
    bus.d_gnt     = d_win;
    bus.mem_en    = i_win || (d_win && !d_fault);
    bus.mem_we    = '0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (i_win) begin
      bus.mem_addr = bus.i_addr[ADDR_W-1:2];
    end else if (d_win && !d_fault) begin
      bus.mem_addr = bus.d_addr[ADDR_W-1:2];
      if (bus.d_we) begin
        bus.mem_we    = d_strb;
        bus.mem_wdata = d_wlane;
      end
    end
  end

  always_comb begin
    starve_cnt_d = '0;
    if (bus.i_req && !i_win) begin
      starve_cnt_d = (starve_cnt_q == CNT_MAX) ? starve_cnt_q : starve_cnt_q + 1'b1;
    end
  end

  always_comb begin
    rsp_d  = RSP_NONE;
    off_d  = off_q;
    size_d = size_q;
    sgn_d  = sgn_q;
    if (i_win) begin
      rsp_d = RSP_I_RD;
    end else if (d_win) begin
      if (d_fault) begin
        rsp_d = RSP_D_ERR;
      end else if (bus.d_we) begin
        rsp_d = RSP_D_WR;
      end else begin
        rsp_d = RSP_D_RD;
      end
      off_d  = d_off;
      size_d = bus.d_size;
      sgn_d  = bus.d_signed;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_q        <= RSP_NONE;
      starve_cnt_q <= '0;
      off_q        <= 2'b00;
      size_q       <= 2'b00;
      sgn_q        <= 1'b0;
    end else begin
      rsp_q        <= rsp_d;
      starve_cnt_q <= starve_cnt_d;
      off_q        <= off_d;
      size_q       <= size_d;
      sgn_q        <= sgn_d;
    end
  end

  // Load extraction uses the offset captured at grant, already truncated to the size's alignment.
  always_comb begin
    rd_half = off_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    rd_byte = off_q[0] ? rd_half[15:8] : rd_half[7:0];
    case (size_q)
      2'd0:    ld_val = sgn_q ? {{24{rd_byte[7]}}, rd_byte} : {24'h0, rd_byte};
      2'd1:    ld_val = sgn_q ? {{16{rd_half[15]}}, rd_half} : {16'h0, rd_half};
      default: ld_val = bus.mem_rdata;
    endcase
  end

  always_comb begin
    bus.i_rvalid = (rsp_q == RSP_I_RD);
    bus.i_rdata  = (rsp_q == RSP_I_RD) ? bus.mem_rdata : 32'h0;
    bus.d_rvalid = (rsp_q == RSP_D_RD) || (rsp_q == RSP_D_WR) || (rsp_q == RSP_D_ERR);
    bus.d_rdata  = (rsp_q == RSP_D_RD) ? ld_val : 32'h0;
    bus.d_err    = range_chk_en && (rsp_q == RSP_D_ERR);
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: the bench plays core and RAM; expected responses are queued at grant and popped one cycle later.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(32)) bus ();

  mem_arbiter #(
    .ADDR_W    (32),
    .DMEM_START(32'h0020_0000),
    .DMEM_END  (32'h0025_0000),
    .MAX_WAIT  (4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // RAM model: byte-strobed writes, registered reads.
  logic [31:0] ram [logic [29:0]];
  logic [31:0] ram_w;
  always @(posedge clk) begin
    if (bus.mem_en) begin
      ram_w = ram.exists(bus.mem_addr) ? ram[bus.mem_addr] : 32'h0;
      if (bus.mem_we == 4'b0000) begin
        bus.mem_rdata <= ram_w;
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (bus.mem_we[b]) ram_w[8*b +: 8] = bus.mem_wdata[8*b +: 8];
        end
        ram[bus.mem_addr] = ram_w;
      end
    end
  end

  typedef struct packed {
    logic [1:0]  kind;   // 0 none, 1 fetch, 2 data
    logic [31:0] data;
    logic        err;
  } rsp_t;

  rsp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic rsp_t mk_rsp(input logic [1:0] k, input logic [31:0] d, input logic e);
    rsp_t r;
    r.kind = k;
    r.data = d;
    r.err  = e;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_mem(input string tag, input logic [3:0] we, input logic [29:0] a, input logic [31:0] wd);
    chk({tag, ":mem_we"}, 32'(bus.mem_we), 32'(we));
    chk({tag, ":mem_addr"}, 32'(bus.mem_addr), 32'(a));
    chk({tag, ":mem_wdata"}, bus.mem_wdata, wd);
  endtask

  task automatic resp_check(input string tag);
    rsp_t e;
    e = '0;
    if (exp_q.size() != 0) e = exp_q.pop_front();
    chk({tag, ":i_rvalid"}, 32'(bus.i_rvalid), 32'(e.kind == 2'd1));
    chk({tag, ":i_rdata"}, bus.i_rdata, (e.kind == 2'd1) ? e.data : 32'h0);
    chk({tag, ":d_rvalid"}, 32'(bus.d_rvalid), 32'(e.kind == 2'd2));
    chk({tag, ":d_rdata"}, bus.d_rdata, (e.kind == 2'd2) ? e.data : 32'h0);
    chk({tag, ":d_err"}, 32'(bus.d_err), 32'(e.err));
  endtask

  // Called just after inputs settle: checks grants, queues the expected response, crosses the edge.
  task automatic cyc(input string tag, input bit ig, input bit dg, input bit en, input rsp_t r);
    chk({tag, ":i_gnt"}, 32'(bus.i_gnt), 32'(ig));
    chk({tag, ":d_gnt"}, 32'(bus.d_gnt), 32'(dg));
    chk({tag, ":mem_en"}, 32'(bus.mem_en), 32'(en));
    exp_q.push_back(r);
    @(posedge clk);
    #1;
    resp_check(tag);
  endtask

  task automatic drv_d(input bit we, input logic [31:0] a, input logic [1:0] sz, input bit sg, input logic [31:0] wd);
    bus.d_req    = 1'b1;
    bus.d_we     = we;
    bus.d_addr   = a;
    bus.d_size   = sz;
    bus.d_signed = sg;
    bus.d_wdata  = wd;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected summary");
    $fatal(1, "watchdog");
  end

  initial begin
    bit want_i;
    rst_n = 1'b0;
    bus.i_req = 1'b1;
    bus.i_addr = 32'h10;
    drv_d(1'b1, 32'h0020_0000, 2'd2, 1'b0, 32'hFFFF_FFFF);
    ram[30'h0_0004] = 32'h0050_0093;
    ram[30'h8_0000] = 32'h0;
    ram[30'h8_0004] = 32'hCAFE_F00D;
    ram[30'h9_3FFF] = 32'h0BAD_BEEF;
    ram[30'h9_4000] = 32'h5A5A_5A5A;
    ram[30'h4_0000] = 32'h0;

    // Reset: requests high, everything still held at 0.
    repeat (2) @(posedge clk);
    #2;
    chk("rst:i_gnt", 32'(bus.i_gnt), 32'h0);
    chk("rst:d_gnt", 32'(bus.d_gnt), 32'h0);
    chk("rst:mem_en", 32'(bus.mem_en), 32'h0);
    chk_mem("rst", 4'b0000, 30'h0, 32'h0);
    resp_check("rst");
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    bus.i_req = 1'b1;
    bus.i_addr = 32'h10;
    #1;
    chk_mem("fetch", 4'b0000, 30'h4, 32'h0);
    cyc("fetch", 1'b1, 1'b0, 1'b1, mk_rsp(2'd1, 32'h0050_0093, 1'b0));

    // Contention: D,D,D,D,I repeating.
    drv_d(1'b0, 32'h0020_0010, 2'd2, 1'b0, 32'h0);
    for (int k = 0; k < 10; k++) begin
      want_i = (k % 5) == 4;
      #1;
      chk(
        $sformatf("cont%0d:mem_addr", k), 32'(bus.mem_addr), want_i ? 32'h4 : 32'h8_0004
      );
      cyc($sformatf("cont%0d", k), want_i, !want_i, 1'b1,
          want_i ? mk_rsp(2'd1, 32'h0050_0093, 1'b0) : mk_rsp(2'd2, 32'hCAFE_F00D, 1'b0));
    end
    bus.i_req = 1'b0;

    drv_d(1'b1, 32'h0020_0003, 2'd0, 1'b0, 32'h1234_56A5);
    #1;
    chk_mem("sb", 4'b1000, 30'h8_0000, 32'hA5A5_A5A5);
    cyc("sb", 1'b0, 1'b1, 1'b1, mk_rsp(2'd2, 32'h0, 1'b0));
    drv_d(1'b0, 32'h0020_0003, 2'd0, 1'b1, 32'h0);
    #1;
    chk_mem("lb", 4'b0000, 30'h8_0000, 32'h0);
    cyc("lb", 1'b0, 1'b1, 1'b1, mk_rsp(2'd2, 32'hFFFF_FFA5, 1'b0));
    drv_d(1'b0, 32'h0020_0003, 2'd0, 1'b0, 32'h0);
    #1;
    cyc("lbu", 1'b0, 1'b1, 1'b1, mk_rsp(2'd2, 32'h0000_00A5, 1'b0));

    drv_d(1'b1, 32'h0020_0002, 2'd1, 1'b0, 32'hFFFF_8001);
    #1;
    chk_mem("sh", 4'b1100, 30'h8_0000, 32'h8001_8001);
    cyc("sh", 1'b0, 1'b1, 1'b1, mk_rsp(2'd2, 32'h0, 1'b0));
    drv_d(1'b0, 32'h0020_0002, 2'd1, 1'b1, 32'h0);
    #1;
    cyc("lh", 1'b0, 1'b1, 1'b1, mk_rsp(2'd2, 32'hFFFF_8001, 1'b0));
    drv_d(1'b0, 32'h0020_0002, 2'd1, 1'b0, 32'h0);
    #1;
    cyc("lhu", 1'b0, 1'b1, 1'b1, mk_rsp(2'd2, 32'h0000_8001, 1'b0));
    drv_d(1'b0, 32'h0020_0002, 2'd0, 1'b1, 32'h0);
    #1;
    cyc("lb_lane2", 1'b0, 1'b1, 1'b1, mk_rsp(2'd2, 32'h0000_0001, 1'b0));
    drv_d(1'b0, 32'h0024_FFFC, 2'd3, 1'b0, 32'h0);
    #1;
    chk_mem("lw_top", 4'b0000, 30'h9_3FFF, 32'h0);
    cyc("lw_top", 1'b0, 1'b1, 1'b1, mk_rsp(2'd2, 32'h0BAD_BEEF, 1'b0));

    // Misaligned and out-of-range accesses.
    drv_d(1'b0, 32'h0020_0003, 2'd1, 1'b1, 32'h0);
    #1;
`ifdef ARB_RANGE_CHECK_EN
    chk_mem("lh_mis", 4'b0000, 30'h0, 32'h0);
    cyc("lh_mis", 1'b0, 1'b1, 1'b0, mk_rsp(2'd2, 32'h0, 1'b1));
`else
    chk_mem("lh_mis", 4'b0000, 30'h8_0000, 32'h0);
    cyc("lh_mis", 1'b0, 1'b1, 1'b1, mk_rsp(2'd2, 32'hFFFF_8001, 1'b0));
`endif
    drv_d(1'b0, 32'h0020_0001, 2'd2, 1'b0, 32'h0);
    #1;
`ifdef ARB_RANGE_CHECK_EN
    chk_mem("lw_mis", 4'b0000, 30'h0, 32'h0);
    cyc("lw_mis", 1'b0, 1'b1, 1'b0, mk_rsp(2'd2, 32'h0, 1'b1));
`else
    chk_mem("lw_mis", 4'b0000, 30'h8_0000, 32'h0);
    cyc("lw_mis", 1'b0, 1'b1, 1'b1, mk_rsp(2'd2, 32'h8001_0000, 1'b0));
`endif
    bus.i_req = 1'b1;
    bus.i_addr = 32'h10;
    drv_d(1'b1, 32'h0010_0000, 2'd2, 1'b0, 32'hDEAD_BEEF);
    #1;
`ifdef ARB_RANGE_CHECK_EN
    chk_mem("sw_low", 4'b0000, 30'h0, 32'h0);
    cyc("sw_low", 1'b0, 1'b1, 1'b0, mk_rsp(2'd2, 32'h0, 1'b1));
`else
    chk_mem("sw_low", 4'b1111, 30'h4_0000, 32'hDEAD_BEEF);
    cyc("sw_low", 1'b0, 1'b1, 1'b1, mk_rsp(2'd2, 32'h0, 1'b0));
`endif
    bus.i_req = 1'b0;
    drv_d(1'b0, 32'h0025_0000, 2'd2, 1'b0, 32'h0);
    #1;
`ifdef ARB_RANGE_CHECK_EN
    cyc("lw_end", 1'b0, 1'b1, 1'b0, mk_rsp(2'd2, 32'h0, 1'b1));
`else
    cyc("lw_end", 1'b0, 1'b1, 1'b1, mk_rsp(2'd2, 32'h5A5A_5A5A, 1'b0));
`endif

    // Reset while a load response is pending.
    drv_d(1'b0, 32'h0020_0010, 2'd2, 1'b0, 32'h0);
    #1;
    chk("rstmid:d_gnt", 32'(bus.d_gnt), 32'h1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.d_req = 1'b0;
    #1;
    chk("rstmid:d_rvalid", 32'(bus.d_rvalid), 32'h0);
    chk("rstmid:d_rdata", bus.d_rdata, 32'h0);
    chk("rstmid:mem_en", 32'(bus.mem_en), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    cyc("post_rst_idle", 1'b0, 1'b0, 1'b0, mk_rsp(2'd0, 32'h0, 1'b0));
    bus.i_req = 1'b1;
    bus.i_addr = 32'h10;
    #1;
    cyc("post_rst_fetch", 1'b1, 1'b0, 1'b1, mk_rsp(2'd1, 32'h0050_0093, 1'b0));
    bus.i_req = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
